// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, encodings and lane-enable helper for the data memory responder
package dmem_pkg;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;
    localparam logic [1:0] SIZE_NONE = 2'b11;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Byte-lane enables for a little-endian word; word ignores addr_lo, half ignores addr_lo[0].
    function automatic logic [3:0] be_of(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            SIZE_WORD: be = 4'b1111;
            SIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            SIZE_BYTE: be = 4'b0001 << addr_lo;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - MEM-stage to data memory request/response bundle
interface data_mem_responder_if;

    logic        req;
    logic        write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready_n;
    logic        err;

    modport master (
        output req, write, size, addr, wdata,
        input  rdata, ready_n, err
    );

    modport slave (
        input  req, write, size, addr, wdata,
        output rdata, ready_n, err
    );

endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word-wide storage with per-byte-lane write enables and a registered read port
module dmem_array #(
    parameter int DEPTH_WORDS = 4096,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rd_en,
    input  logic [3:0]    wr_be,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Read returns the value before this edge's lane writes land (read-before-write).
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rdata <= mem[idx];
        end
        for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) begin
                mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data memory responder with wait states; optional DMEM_MISALIGN_CHK_EN misalign check
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    data_mem_responder_if.slave bus
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             commit;
    logic             mis;
    logic [3:0]       be;
    logic [3:0]       wr_be;
    logic [AW-1:0]    idx;
    logic [31:0]      arr_rdata;
    logic             rd_vld;
    logic             ready_n_q;
    logic             unused_addr;

    assign idx         = bus.addr[AW+1:2];
    assign unused_addr = ^bus.addr[31:AW+2];

`ifdef DMEM_MISALIGN_CHK_EN
    logic err_q;

    assign mis = ((bus.size == SIZE_HALF) && bus.addr[0]) ||
                 ((bus.size == SIZE_WORD) && (bus.addr[1:0] != 2'b00));

    // err mirrors the RESP cycle of a misaligned access and is low everywhere else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= commit && mis;
        end
    end

    assign bus.err = err_q;
`else
    assign mis     = 1'b0;
    assign bus.err = 1'b0;
`endif

    // Next-state and wait-counter decode; a dropped req in WAIT abandons the access.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ST_IDLE: begin
                if (bus.req) begin
                    cnt_nx   = CNT_W'(WAIT_CYCLES);
                    state_nx = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!bus.req) begin
                    cnt_nx   = '0;
                    state_nx = ST_IDLE;
                end else begin
                    cnt_nx = cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state_nx = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // The commit edge is the one entering RESP; reset held low blocks any write.
    assign commit = rst_n && (state_nx == ST_RESP) && (state != ST_RESP);
    assign be     = mis ? 4'b0000 : be_of(bus.size, bus.addr[1:0]);
    assign wr_be  = (commit && bus.write) ? be : 4'b0000;

    // State, counter and the registered completion strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            ready_n_q <= 1'b1;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            ready_n_q <= (state_nx != ST_RESP);
        end
    end

    // rdata is zero after reset and after a misaligned access, otherwise the array's read register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld <= 1'b0;
        end else if (commit) begin
            rd_vld <= !mis;
        end
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk  (clk),
        .rd_en(commit),
        .wr_be(wr_be),
        .idx  (idx),
        .wdata(bus.wdata),
        .rdata(arr_rdata)
    );

    assign bus.rdata   = rd_vld ? arr_rdata : 32'h0;
    assign bus.ready_n = ready_n_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    data_mem_responder_if bus1 ();
    data_mem_responder_if bus3 ();

    data_mem_responder #(.DEPTH_WORDS(4096), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
    );
    data_mem_responder #(.DEPTH_WORDS(4096), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic drive(input int d, input logic rq, input logic wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
        if (d == 3) begin
            bus3.req = rq; bus3.write = wr; bus3.size = sz; bus3.addr = a; bus3.wdata = wd;
        end else begin
            bus1.req = rq; bus1.write = wr; bus1.size = sz; bus1.addr = a; bus1.wdata = wd;
        end
    endtask

    function automatic logic rdy_n(input int d);
        return (d == 3) ? bus3.ready_n : bus1.ready_n;
    endfunction

    // One access: req raised at a negedge, polled at negedges until ready_n is low, then dropped.
    task automatic access(input int d, input logic wr, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output int lat);
        bit done;
        done = 0;
        lat  = 0;
        rd   = '0;
        er   = 1'b0;
        @(negedge clk);
        drive(d, 1'b1, wr, sz, a, wd);
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            lat++;
            if (rdy_n(d) == 1'b0) begin
                rd   = (d == 3) ? bus3.rdata : bus1.rdata;
                er   = (d == 3) ? bus3.err : bus1.err;
                done = 1;
            end
        end
        if (!done) check("access_timeout", 32'(lat), 32'(0));
        drive(d, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          lows;
    int          gap;

    initial begin
        n_checks = 0;
        n_errors = 0;
        drive(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        drive(3, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready_n", 32'(bus1.ready_n), 32'(1));
        check("rst_rdata", bus1.rdata, 32'h0);
        check("rst_err", 32'(bus1.err), 32'(0));
        rst_n = 1'b1;

        // Preload through the port.
        access(1, 1'b1, 2'b00, 32'h0000_0000, 32'ha0b1_c2d3, rd, er, lat);
        access(1, 1'b1, 2'b00, 32'h0000_1234, 32'h0000_0000, rd, er, lat);
        access(3, 1'b1, 2'b00, 32'h0000_0008, 32'h55aa_1234, rd, er, lat);

        // Case 1: load word, latency and data.
        access(1, 1'b0, 2'b00, 32'h0, 32'h0, rd, er, lat);
        check("c1_latency", 32'(lat), 32'(2));
        check("c1_rdata", rd, 32'ha0b1_c2d3);
        @(negedge clk);
        check("c1_single_cycle", 32'(bus1.ready_n), 32'(1));
        check("c1_rdata_hold", bus1.rdata, 32'ha0b1_c2d3);

        // Case 2: store byte into lane 2.
        access(1, 1'b1, 2'b10, 32'h0000_1236, 32'h2121_2121, rd, er, lat);
        check("c2_sb_prewrite", rd, 32'h0);
        access(1, 1'b0, 2'b00, 32'h0000_1234, 32'h0, rd, er, lat);
        check("c2_lw", rd, 32'h0021_0000);

        // Case 3: store half (upper), then store word.
        access(1, 1'b1, 2'b01, 32'h0000_1236, 32'h4321_4321, rd, er, lat);
        access(1, 1'b0, 2'b00, 32'h0000_1234, 32'h0, rd, er, lat);
        check("c3_sh", rd, 32'h4321_0000);
        access(1, 1'b1, 2'b00, 32'h0000_1234, 32'h8765_4321, rd, er, lat);
        check("c3_sw_prewrite", rd, 32'h4321_0000);
        access(1, 1'b0, 2'b00, 32'h0000_1234, 32'h0, rd, er, lat);
        check("c3_sw", rd, 32'h8765_4321);

        // Case 4: abort during WAIT, then reset mid-WAIT (WAIT_CYCLES=3).
        access(3, 1'b0, 2'b00, 32'h0000_0008, 32'h0, rd, er, lat);
        check("c4_latency3", 32'(lat), 32'(4));
        check("c4_lw_pre", rd, 32'h55aa_1234);
        @(negedge clk);
        drive(3, 1'b1, 1'b1, 2'b00, 32'h0000_0008, 32'hffff_ffff);
        @(negedge clk);
        drive(3, 1'b0, 1'b1, 2'b00, 32'h0000_0008, 32'hffff_ffff);
        lows = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus3.ready_n == 1'b0) lows++;
        end
        check("c4_abort_no_ready", 32'(lows), 32'(0));
        access(3, 1'b0, 2'b00, 32'h0000_0008, 32'h0, rd, er, lat);
        check("c4_abort_mem", rd, 32'h55aa_1234);
        @(negedge clk);
        drive(3, 1'b1, 1'b1, 2'b00, 32'h0000_0008, 32'hdead_beef);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("c4_rst_ready_n", 32'(bus3.ready_n), 32'(1));
        check("c4_rst_rdata", bus3.rdata, 32'h0);
        drive(3, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        access(3, 1'b0, 2'b00, 32'h0000_0008, 32'h0, rd, er, lat);
        check("c4_rst_no_write", rd, 32'h55aa_1234);

        // Case 5: back-to-back loads with req held, then a size=11 store.
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
        lows = 0;
        for (int i = 0; i < 20 && lows == 0; i++) begin
            @(negedge clk);
            if (bus1.ready_n == 1'b0) lows = 1;
        end
        check("c5_first_pulse", 32'(lows), 32'(1));
        check("c5_first_rdata", bus1.rdata, 32'ha0b1_c2d3);
        drive(1, 1'b1, 1'b0, 2'b00, 32'h0000_1234, 32'h0);
        gap = 0;
        lows = 0;
        for (int i = 0; i < 20 && lows == 0; i++) begin
            @(negedge clk);
            if (bus1.ready_n == 1'b0) lows = 1;
            else gap++;
        end
        drive(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        check("c5_gap", 32'(gap), 32'(2));
        check("c5_second_rdata", bus1.rdata, 32'h8765_4321);
        @(negedge clk);
        check("c5_no_double", 32'(bus1.ready_n), 32'(1));
        access(1, 1'b1, 2'b11, 32'h0000_1234, 32'hffff_ffff, rd, er, lat);
        check("c5_none_latency", 32'(lat), 32'(2));
        access(1, 1'b0, 2'b00, 32'h0000_1234, 32'h0, rd, er, lat);
        check("c5_none_mem", rd, 32'h8765_4321);

        // Case 6: misaligned word store.
`ifdef DMEM_MISALIGN_CHK_EN
        access(1, 1'b1, 2'b00, 32'h0000_1235, 32'h0bad_f00d, rd, er, lat);
        check("c6_err", 32'(er), 32'(1));
        check("c6_rdata_zero", rd, 32'h0);
        @(negedge clk);
        check("c6_err_low_after", 32'(bus1.err), 32'(0));
        access(1, 1'b0, 2'b00, 32'h0000_1234, 32'h0, rd, er, lat);
        check("c6_mem_unchanged", rd, 32'h8765_4321);
        check("c6_err_aligned", 32'(er), 32'(0));
`else
        access(1, 1'b1, 2'b00, 32'h0000_1235, 32'h0bad_f00d, rd, er, lat);
        check("c6_err_tied", 32'(er), 32'(0));
        check("c6_prewrite", rd, 32'h8765_4321);
        access(1, 1'b0, 2'b00, 32'h0000_1234, 32'h0, rd, er, lat);
        check("c6_word_ignores_lo", rd, 32'h0bad_f00d);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
